// File: rtl/stoch_to_bin.sv
// Stochastic-to-binary converter: counts the ones of a unipolar bitstream
// over a window of 2^WIDTH clocks and presents the saturated count as a
// WIDTH-bit estimate with a one-cycle valid strobe.
module stoch_to_bin #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cont,
   input  logic             in,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] out
);

   typedef enum logic {IDLE, COUNT} state_t;

   localparam logic [WIDTH-1:0] WIN_LAST = {WIDTH{1'b1}};

   state_t             state_q;
   logic [WIDTH-1:0]   win_q;
   logic [WIDTH:0]     ones_q;
   logic [WIDTH-1:0]   out_q;
   logic               valid_q;

   logic [WIDTH:0]     ones_d;
   logic [WIDTH-1:0]   sat_d;
   logic               last_d;

   // Running count including the current sample, and its saturated form.
   // A full window of ones (N) does not fit WIDTH bits, so clamp to all-ones.
   always_comb begin
      ones_d = ones_q + (WIDTH+1)'(in);
      sat_d  = ones_d[WIDTH] ? {WIDTH{1'b1}} : ones_d[WIDTH-1:0];
      last_d = (win_q == WIN_LAST);
   end

   // Conversion FSM; all outputs are registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         win_q   <= '0;
         ones_q  <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // in is not sampled on the accepting edge.
               if (start) begin
                  state_q <= COUNT;
                  win_q   <= '0;
                  ones_q  <= '0;
               end
            end
            COUNT: begin
               if (last_d) begin
                  out_q   <= sat_d;
                  valid_q <= 1'b1;
                  win_q   <= '0;
                  ones_q  <= '0;
                  // Continuous mode rolls straight into the next window.
                  if (!cont) state_q <= IDLE;
               end else begin
                  win_q  <= win_q + 1'b1;
                  ones_q <= ones_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy  = (state_q == COUNT);
   assign valid = valid_q;
   assign out   = out_q;

endmodule

// File: tb/tb_stoch_to_bin.sv
// Randomized and directed bench for stoch_to_bin (WIDTH=4) against a
// window-level reference model built on a sample queue.
module tb_stoch_to_bin;
   localparam int W = 4;
   localparam int N = 1 << W;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         cont = 1'b0;
   logic         in = 1'b0;
   logic         busy, valid;
   logic [W-1:0] out;

   int checks = 0;
   int errors = 0;

   // reference model: a window is just the list of samples seen since start
   bit m_busy = 1'b0;
   bit m_valid = 1'b0;
   int m_out = 0;
   bit win[$];

   always #5 clk = ~clk;

   stoch_to_bin #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .cont(cont), .in(in),
      .busy(busy), .valid(valid), .out(out)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0; m_valid = 1'b0; m_out = 0; win.delete();
   endtask

   task automatic model_edge(input bit s, input bit c, input bit b);
      int ones;
      m_valid = 1'b0;
      if (!m_busy) begin
         if (s) begin m_busy = 1'b1; win.delete(); end
      end else begin
         win.push_back(b);
         if (win.size() == N) begin
            ones = 0;
            foreach (win[i]) ones += win[i];
            m_out   = (ones > N-1) ? N-1 : ones;
            m_valid = 1'b1;
            m_busy  = c;
            win.delete();
         end
      end
   endtask

   // drive inputs, take one edge, then compare all outputs on the negedge
   task automatic tick(input bit s, input bit c, input bit b);
      start = s; cont = c; in = b;
      @(posedge clk);
      if (rst) model_reset(); else model_edge(s, c, b);
      @(negedge clk);
      chk("busy", busy, m_busy);
      chk("valid", valid, m_valid);
      chk("out", out, m_out);
   endtask

   // start pulse followed by one full window of samples
   task automatic run_win(input logic [N-1:0] bits, input bit c, input logic [N-1:0] restart);
      tick(1'b1, c, 1'b0);
      for (int i = 0; i < N; i++) tick(restart[i], c, bits[i]);
   endtask

   task automatic async_reset();
      #2 rst = 1'b1;
      #1 model_reset();
      chk("rst_busy", busy, 0);
      chk("rst_valid", valid, 0);
      chk("rst_out", out, 0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   function automatic logic [N-1:0] rand_bits(input int p);
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 99) < p);
      return v;
   endfunction

   initial begin
      logic [N-1:0] bits;
      logic [3:0]   lfsr;
      int           p;

      // reset held for 4 cycles
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      run_win('0, 1'b0, '0);
      chk("zeros_out", out, 0);
      tick(1'b0, 1'b0, 1'b0);

      run_win('1, 1'b0, '0);
      chk("sat_out", out, N-1);
      tick(1'b0, 1'b0, 1'b0);

      bits = 16'h5555;
      run_win(bits, 1'b0, '0);
      chk("alt_out", out, 8);
      bits = 16'h001F;
      run_win(bits, 1'b0, '0);
      chk("five_out", out, 5);
      tick(1'b0, 1'b0, 1'b0);

      // continuous mode: three back-to-back windows
      tick(1'b1, 1'b1, 1'b0);
      bits = 16'h000F;
      for (int i = 0; i < N; i++) tick(1'b0, 1'b1, bits[i]);
      chk("cont_w1", out, 4);
      bits = 16'h0FFF;
      for (int i = 0; i < N; i++) tick(1'b0, 1'b1, bits[i]);
      chk("cont_w2", out, 12);
      for (int i = 0; i < N; i++) tick(1'b0, (i != N-1), 1'b1);
      chk("cont_w3", out, N-1);
      tick(1'b0, 1'b0, 1'b0);

      // start pulses during the window are ignored
      bits = rand_bits(50);
      run_win(bits, 1'b0, 16'h8004);
      tick(1'b0, 1'b0, 1'b0);

      // reset after sample 9 aborts the window
      tick(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) tick(1'b0, 1'b0, 1'b1);
      async_reset();
      run_win(rand_bits(70), 1'b0, '0);
      tick(1'b0, 1'b0, 1'b0);

      // scaled adder x=1, y=0: output is just its pseudo-random select
      lfsr = 4'b0001;
      for (int i = 0; i < N; i++) begin
         bits[i] = lfsr[0] ? 1'b1 : 1'b0;
         lfsr = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
      end
      run_win(bits, 1'b0, '0);
      chk("adder_half", (out >= 7 && out <= 9), 1);
      tick(1'b0, 1'b0, 1'b0);

      // random mix of start, cont, density and occasional resets
      p = 50;
      for (int i = 0; i < 1500; i++) begin
         if (i % 64 == 0) p = $urandom_range(0, 100);
         if ($urandom_range(0, 499) == 0) async_reset();
         else tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0),
                   ($urandom_range(0, 99) < p));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
